// File: rtl/scr_pkg.sv
// Shared types and helpers for the pre-scrambler deserializer and the
// post-unscrambler serializer.
package scr_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned SIZE_W = 7;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [SIZE_W-1:0] size_t;

  // Left-align the cnt valid low bits of acc so the first received bit
  // lands at the MSB and unused low bits are zero.
  function automatic word_t align_word(input word_t acc, input size_t cnt);
    size_t sh;
    sh = size_t'(WORD_W) - cnt;
    return acc << sh;
  endfunction

endpackage

// File: rtl/pre_scr_deser.sv
// Serial-to-word deserializer feeding the pre-scrambler FIFO. Bits are
// collected MSB-first; full words or flushed partial words are moved to a
// holding register and written to the FIFO with their valid-bit count.
module pre_scr_deser #(
  parameter int unsigned WORD_W = scr_pkg::WORD_W,
  parameter int unsigned SIZE_W = scr_pkg::SIZE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              bit_in,
  input  logic              bit_wr,
  output logic              bit_ready,
  input  logic              flush,
  input  logic              scrambled_full,
  output logic              scrambled_wr,
  output logic [WORD_W-1:0] data_out,
  output logic [SIZE_W-1:0] size_out
);

  import scr_pkg::align_word;

  logic [WORD_W-1:0] acc;
  logic [SIZE_W-1:0] cnt;
  logic [WORD_W-1:0] data_q;
  logic [SIZE_W-1:0] size_q;
  logic              flush_pend;
  logic              out_valid;

  logic              cnt_full;
  logic              cnt_zero;
  logic              accept;
  logic              xfer;

  // Handshake and transfer decode; bit_ready deliberately ignores clk_en.
  always_comb begin
    cnt_full     = (cnt == SIZE_W'(WORD_W));
    cnt_zero     = (cnt == '0);
    bit_ready    = !cnt_full && !flush_pend;
    scrambled_wr = clk_en && out_valid && !scrambled_full;
    accept       = clk_en && bit_wr && bit_ready;
    xfer         = clk_en && (cnt_full || (flush_pend && !cnt_zero)) &&
                   (!out_valid || scrambled_wr);
    data_out     = data_q;
    size_out     = size_q;
  end

  // Accumulator and bit counter. An accept never coincides with an xfer
  // because both xfer conditions hold bit_ready low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (xfer) begin
      cnt <= '0;
    end else if (accept) begin
      acc <= {acc[WORD_W-2:0], bit_in};
      cnt <= cnt + SIZE_W'(1);
    end
  end

  // Holding register loaded on transfer; stays stable while the FIFO is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      size_q <= '0;
    end else if (xfer) begin
      data_q <= align_word(acc, cnt);
      size_q <= cnt;
    end
  end

  // Holding-register occupancy: a same-edge load and write keeps it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
    end else if (scrambled_wr) begin
      out_valid <= 1'b0;
    end
  end

  // Flush latch. A pending flush clears when its partial word moves out, or
  // as an empty flush once the counter is zero (which also retires a flush
  // that arrived with the 64th bit, one enabled cycle after the full word).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (clk_en) begin
      if (flush_pend) begin
        if ((xfer && !cnt_full) || (cnt_zero && !accept)) begin
          flush_pend <= 1'b0;
        end
      end else if (flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pre_scr_deser.sv
// Directed self-checking bench for pre_scr_deser.
module tb_pre_scr_deser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_wr = 1'b0;
  logic        bit_ready;
  logic        flush = 1'b0;
  logic        scrambled_full = 1'b0;
  logic        scrambled_wr;
  logic [63:0] data_out;
  logic [6:0]  size_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [63:0] d;
    logic [6:0]  s;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    logic [63:0] pat;
    int unsigned n;
    bit          fl;
    logic [63:0] exp_d;
    logic [6:0]  exp_s;
  } vec_t;
  vec_t vecs[6];

  bit          cnt_rdy = 1'b0;
  int unsigned rdy_low = 0;
  bit          tog = 1'b0;
  bit          drv_done = 1'b0;

  pre_scr_deser #(.WORD_W(64), .SIZE_W(7)) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .bit_in         (bit_in),
    .bit_wr         (bit_wr),
    .bit_ready      (bit_ready),
    .flush          (flush),
    .scrambled_full (scrambled_full),
    .scrambled_wr   (scrambled_wr),
    .data_out       (data_out),
    .size_out       (size_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Write monitor: inputs only change just after posedge, so a strobe seen
  // at negedge commits at the following posedge.
  always @(negedge clk) begin
    if (cnt_rdy && !bit_ready) rdy_low++;
    if (scrambled_wr === 1'b1) begin
      chk("wr_with_clk_en", {63'd0, clk_en}, 64'd1);
      chk("wr_size_nonzero", {63'd0, (size_out != 7'd0)}, 64'd1);
      wq.push_back('{d: data_out, s: size_out});
    end
  end

  // Clock-enable toggler, active only while tog is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog) clk_en = ~clk_en;
    end
  end

  task automatic send_bit(input logic b);
    int unsigned t;
    t = 0;
    bit_in = b;
    bit_wr = 1'b1;
    forever begin
      @(negedge clk);
      if (bit_ready && clk_en) begin
        @(posedge clk);
        #1;
        break;
      end
      t++;
      if (t > 1000) begin
        chk("send_bit_timeout", 64'd0, 64'd1);
        break;
      end
    end
    bit_wr = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_writes(input int unsigned n, input int unsigned budget);
    int unsigned t;
    t = 0;
    while (wq.size() < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("write_timeout", {63'd0, (wq.size() >= n)}, 64'd1);
  endtask

  task automatic pop_check(input string name, input logic [63:0] ed, input logic [6:0] es);
    wr_t w;
    if (wq.size() == 0) begin
      chk({name, "_missing"}, 64'd0, 64'd1);
    end else begin
      w = wq.pop_front();
      chk({name, "_data"}, w.d, ed);
      chk({name, "_size"}, {57'd0, w.s}, {57'd0, es});
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [63:0]  pat;
  logic [129:0] strm;

  initial begin
    vecs[0] = '{pat: 64'hAAAA_AAAA_AAAA_AAAA, n: 64, fl: 1'b0,
                exp_d: 64'hAAAA_AAAA_AAAA_AAAA, exp_s: 7'd64};
    vecs[1] = '{pat: 64'hB800_0000_0000_0000, n: 5, fl: 1'b1,
                exp_d: 64'hB800_0000_0000_0000, exp_s: 7'd5};
    vecs[2] = '{pat: 64'h8000_0000_0000_0000, n: 1, fl: 1'b1,
                exp_d: 64'h8000_0000_0000_0000, exp_s: 7'd1};
    vecs[3] = '{pat: 64'hFFFF_FFFF_FFFF_FFFF, n: 63, fl: 1'b1,
                exp_d: 64'hFFFF_FFFF_FFFF_FFFE, exp_s: 7'd63};
    vecs[4] = '{pat: 64'h0123_4567_89AB_CDEF, n: 64, fl: 1'b0,
                exp_d: 64'h0123_4567_89AB_CDEF, exp_s: 7'd64};
    vecs[5] = '{pat: 64'hDEF5_5555_5555_5555, n: 12, fl: 1'b1,
                exp_d: 64'hDEF0_0000_0000_0000, exp_s: 7'd12};

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_data", data_out, 64'd0);
    chk("rst_size", {57'd0, size_out}, 64'd0);
    chk("rst_wr", {63'd0, scrambled_wr}, 64'd0);
    chk("rst_ready", {63'd0, bit_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Table-driven words
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        rdy_low = 0;
        cnt_rdy = 1'b1;
      end
      pat = vecs[i].pat;
      for (int unsigned k = 0; k < vecs[i].n; k++) send_bit(pat[63-k]);
      if (vecs[i].fl) do_flush();
      wait_writes(1, 20);
      idle(4);
      if (i == 0) begin
        cnt_rdy = 1'b0;
        chk("ready_low_cycles", 64'(rdy_low), 64'd1);
      end
      chk("vec_write_count", 64'(wq.size()), 64'd1);
      pop_check($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_s);
      wq.delete();
      idle(2);
    end

    // Empty flush writes nothing
    do_flush();
    idle(6);
    chk("empty_flush_no_write", 64'(wq.size()), 64'd0);
    chk("empty_flush_ready", {63'd0, bit_ready}, 64'd1);

    // Flush coinciding with the 64th bit: one full word, no empty write
    pat = 64'hC3C3_5A5A_0FF0_9669;
    for (int k = 0; k < 63; k++) send_bit(pat[63-k]);
    flush = 1'b1;
    send_bit(pat[0]);
    flush = 1'b0;
    wait_writes(1, 20);
    idle(6);
    chk("flush64_write_count", 64'(wq.size()), 64'd1);
    pop_check("flush64", 64'hC3C3_5A5A_0FF0_9669, 7'd64);
    chk("flush64_ready", {63'd0, bit_ready}, 64'd1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    do_flush();
    wait_writes(1, 20);
    idle(4);
    pop_check("after_flush64", 64'hA000_0000_0000_0000, 7'd3);
    chk("after_flush64_count", 64'(wq.size()), 64'd0);
    wq.delete();

    // FIFO full across 130 bits
    strm = {64'hF0E1_D2C3_B4A5_9687, 64'h0F1E_2D3C_4B5A_6978, 2'b11};
    scrambled_full = 1'b1;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 130; i++) send_bit(strm[129-i]);
        drv_done = 1'b1;
      end
    join_none
    repeat (100) @(negedge clk);
    chk("stall_hold_data_a", data_out, 64'hF0E1_D2C3_B4A5_9687);
    chk("stall_hold_size_a", {57'd0, size_out}, 64'd64);
    chk("stall_no_wr", {63'd0, scrambled_wr}, 64'd0);
    repeat (45) @(negedge clk);
    chk("stall_hold_data_b", data_out, 64'hF0E1_D2C3_B4A5_9687);
    chk("stall_ready_low", {63'd0, bit_ready}, 64'd0);
    chk("stall_no_writes", 64'(wq.size()), 64'd0);
    @(posedge clk);
    #1 scrambled_full = 1'b0;
    for (int t = 0; t < 50 && !drv_done; t++) begin
      @(posedge clk);
      #1;
    end
    chk("stall_driver_done", {63'd0, drv_done}, 64'd1);
    do_flush();
    wait_writes(3, 20);
    idle(4);
    pop_check("stall_w0", 64'hF0E1_D2C3_B4A5_9687, 7'd64);
    pop_check("stall_w1", 64'h0F1E_2D3C_4B5A_6978, 7'd64);
    pop_check("stall_w2", 64'hC000_0000_0000_0000, 7'd2);
    wq.delete();

    // clk_en toggling every cycle
    pat = 64'h1234_5678_9ABC_DEF0;
    tog = 1'b1;
    for (int k = 0; k < 64; k++) send_bit(pat[63-k]);
    wait_writes(1, 40);
    tog = 1'b0;
    @(posedge clk);
    #2 clk_en = 1'b1;
    idle(4);
    pop_check("clken", 64'h1234_5678_9ABC_DEF0, 7'd64);
    chk("clken_count", 64'(wq.size()), 64'd0);
    wq.delete();

    // Asynchronous reset with cnt=40 and a held word
    scrambled_full = 1'b1;
    for (int k = 0; k < 104; k++) send_bit(1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", data_out, 64'd0);
    chk("arst_size", {57'd0, size_out}, 64'd0);
    chk("arst_ready", {63'd0, bit_ready}, 64'd1);
    scrambled_full = 1'b0;
    #1;
    chk("arst_wr", {63'd0, scrambled_wr}, 64'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    idle(10);
    chk("arst_no_write", 64'(wq.size()), 64'd0);
    send_bit(1'b0);
    send_bit(1'b1);
    do_flush();
    wait_writes(1, 20);
    idle(4);
    pop_check("post_rst", 64'h4000_0000_0000_0000, 7'd2);
    chk("final_queue_empty", 64'(wq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pre_scr_deser.md
# pre_scr_deser

Bit-to-word deserializer on the transmit side of the scrambler path, and the inverse of the post-unscrambler serializer. It collects a serial bit stream MSB-first into 64-bit words. It writes each word, with a 7-bit valid-bit count, into the pre-scrambler FIFO. Partial words are emitted on an explicit flush, so block boundaries survive the FIFO and the downstream serializer reproduces the exact bit stream.

## Interface
Parameters:
- WORD_W, 64, word width in bits.
- SIZE_W, 7, size field width; must hold WORD_W (SIZE_W = $clog2(WORD_W)+1).

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- clk_en  in  1  global clock enable; all state holds when low.
- bit_in  in  1  serial data bit.
- bit_wr  in  1  bit_in valid strobe.
- bit_ready  out  1  deserializer can accept a bit this cycle.
- flush  in  1  end-of-block pulse; emit the partial word.
- scrambled_full  in  1  downstream FIFO full.
- scrambled_wr  out  1  FIFO write strobe.
- data_out  out  WORD_W  word to FIFO; first received bit at bit 63, unused low bits 0.
- size_out  out  SIZE_W  valid bits in data_out, 1..64; never 0.

## Operation
Internal state:
- acc[63:0] is the accumulator.
- cnt[6:0] counts accumulated bits, 0..64.
- flush_pend is the latched flush.
- out_valid marks the holding register (data_out/size_out) as occupied.

Rules:
- bit_ready = (cnt != 64) && ~flush_pend. It is combinational and independent of clk_en.
- Bit accept: clk_en && bit_wr && bit_ready. On accept, acc <= {acc[62:0], bit_in} and cnt <= cnt+1. A bit_wr while bit_ready is low is ignored; the producer must hold the bit.
- Flush latch: clk_en && flush sets flush_pend. A bit accepted in the same cycle belongs to the flushed word. A flush while flush_pend is already set has no effect.
- scrambled_wr = clk_en && out_valid && ~scrambled_full. It is combinational, like the serializer's read strobe.
- Transfer xfer = clk_en && (cnt==64 || (flush_pend && cnt!=0)) && (~out_valid || scrambled_wr). On xfer:
  - data_out <= acc << (64-cnt), which left-aligns the word.
  - size_out <= cnt.
  - cnt <= 0 and out_valid <= 1.
- out_valid clears on scrambled_wr without a simultaneous xfer.
- flush_pend clears in either of two cases:
  - on an xfer taken with cnt != 64;
  - when clk_en && flush_pend && cnt==0 and no bit is accepted. This is an empty flush and writes no word.
- A flush with cnt==64 pending first transfers the full word. The flush then clears as empty on the next enabled cycle.
- No state machine beyond these flags; two implicit phases, FILL (cnt<64) and FULL (cnt==64, waiting for the holding register).

## Timing
- Reset values: acc=0, cnt=0, flush_pend=0, out_valid=0, data_out=0, size_out=0. Outputs after reset: scrambled_wr=0, bit_ready=1. Mid-operation reset discards the partial word and any held word with no write.
- Latency: 64th bit accepted at edge N, xfer at edge N+1, scrambled_wr high during cycle N+1..N+2, write at edge N+2 if not full.
- Throughput: one idle bit_ready cycle per 64 bits when the FIFO is not full. A full FIFO stalls the holding register, then the accumulator, then bit_ready.
- Simultaneous xfer and scrambled_wr: the old word is written and the new word loaded in the same edge; out_valid stays 1.
- clk_en low: no accepts, no flush latch, scrambled_wr=0, all registers hold.
- data_out/size_out stay stable while out_valid && scrambled_full.

## Structure
- Shared package scr_pkg: WORD_W=64, SIZE_W=7, typedef word_t (logic [63:0]), size_t (logic [6:0]). The serializer uses the same types.
- Single module; no sub-module. The left-align shift is an inline combinational function in the package: align_word(acc, cnt).

## Test plan
- 64 bits alternating 1,0 from reset, FIFO empty -> one write, data_out=64'hAAAA_AAAA_AAAA_AAAA, size_out=64. bit_ready is low exactly one cycle.
- 5 bits 1,0,1,1,1 then flush -> data_out=64'hB800_0000_0000_0000, size_out=5, single write.
- Flush with cnt=0, and a flush coinciding with the 64th bit -> no extra write, and no write with size 0.
- scrambled_full held high across 130 bits -> first word held stable and bit_ready drops at cnt=64. After full deasserts, two words are written in order with no bit lost.
- clk_en toggled every other cycle during a 64-bit transfer -> same data and size as the continuous case; scrambled_wr is never asserted with clk_en low.
- rst asserted asynchronously with cnt=40 and out_valid=1 -> all outputs go to reset values immediately; no write after release.
